// File: rtl/id_stage_pipelined.sv
// ARM decode stage: control decode, register file with write-back bypass, NZCV
// status register, RAW hazard detection and the ID/EXE pipeline register.

module ControlUnit (
    input  logic [1:0] mode_i,
    input  logic [3:0] opcode_i,
    input  logic       s_i,
    output logic [3:0] exe_cmd_o,
    output logic       mem_r_en_o,
    output logic       mem_w_en_o,
    output logic       wb_en_o,
    output logic       b_o,
    output logic       s_o
);
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        exe_cmd_o  = 4'b0000;
        mem_r_en_o = 1'b0;
        mem_w_en_o = 1'b0;
        wb_en_o    = 1'b0;
        b_o        = 1'b0;
        s_o        = 1'b0;
        case (mode_i)
            2'b00: begin
                s_o = s_i;
                case (opcode_i)
                    4'b1101: begin exe_cmd_o = 4'b0001; wb_en_o = 1'b1; end // MOV
                    4'b1111: begin exe_cmd_o = 4'b1001; wb_en_o = 1'b1; end // MVN
                    4'b0100: begin exe_cmd_o = 4'b0010; wb_en_o = 1'b1; end // ADD
                    4'b0101: begin exe_cmd_o = 4'b0011; wb_en_o = 1'b1; end // ADC
                    4'b0010: begin exe_cmd_o = 4'b0100; wb_en_o = 1'b1; end // SUB
                    4'b0110: begin exe_cmd_o = 4'b0101; wb_en_o = 1'b1; end // SBC
                    4'b0000: begin exe_cmd_o = 4'b0110; wb_en_o = 1'b1; end // AND
                    4'b1100: begin exe_cmd_o = 4'b0111; wb_en_o = 1'b1; end // ORR
                    4'b0001: begin exe_cmd_o = 4'b1000; wb_en_o = 1'b1; end // EOR
                    4'b1010: exe_cmd_o = 4'b0100;                           // CMP
                    4'b1000: exe_cmd_o = 4'b0110;                           // TST
                    default: exe_cmd_o = 4'b0000;
                endcase
            end
            2'b01: begin
                // The S bit is the load/store selector here, not a flag update.
                exe_cmd_o = 4'b0010;
                if (s_i) begin
                    mem_r_en_o = 1'b1;
                    wb_en_o    = 1'b1;
                end else begin
                    mem_w_en_o = 1'b1;
                end
            end
            2'b10:   b_o = 1'b1;
            default: ;
        endcase
    end
endmodule

module Condition_Check (
    input  logic [3:0] cond_i,
    input  logic [3:0] sr_i,
    output logic       cond_ok_o
);
    logic n, z, c, v;
    assign {n, z, c, v} = sr_i;

    always_comb begin
        cond_ok_o = 1'b0;
        case (cond_i)
            4'b0000: cond_ok_o = z;
            4'b0001: cond_ok_o = !z;
            4'b0010: cond_ok_o = c;
            4'b0011: cond_ok_o = !c;
            4'b0100: cond_ok_o = n;
            4'b0101: cond_ok_o = !n;
            4'b0110: cond_ok_o = v;
            4'b0111: cond_ok_o = !v;
            4'b1000: cond_ok_o = c && !z;
            4'b1001: cond_ok_o = !c || z;
            4'b1010: cond_ok_o = (n == v);
            4'b1011: cond_ok_o = (n != v);
            4'b1100: cond_ok_o = !z && (n == v);
            4'b1101: cond_ok_o = z || (n != v);
            4'b1110: cond_ok_o = 1'b1;
            default: cond_ok_o = 1'b0;
        endcase
    end
endmodule

module id_stage_pipelined #(
    parameter int DATA_W    = 32,
    parameter int NREG_LOG2 = 4,
    parameter int WB_BYPASS = 1,
    parameter int SR_BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    input  logic [31:0]          Instruction_in,
    input  logic [DATA_W-1:0]    PC_in,
    input  logic                 freeze,
    input  logic                 flush,
    input  logic                 WB_EN_in,
    input  logic [NREG_LOG2-1:0] WB_Dest_in,
    input  logic [DATA_W-1:0]    WB_Value_in,
    input  logic [3:0]           SR_in,
    input  logic                 SR_we,
    input  logic [NREG_LOG2-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic [NREG_LOG2-1:0] mem_dest,
    input  logic                 mem_wb_en,
    output logic                 hazard,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    PC,
    output logic [DATA_W-1:0]    Val_Rn,
    output logic [DATA_W-1:0]    Val_Rm,
    output logic                 imm,
    output logic [23:0]          Signed_imm_24,
    output logic [11:0]          Shift_operand,
    output logic [NREG_LOG2-1:0] Dest,
    output logic [NREG_LOG2-1:0] src1_out,
    output logic [NREG_LOG2-1:0] src2_out,
    output logic                 MEM_R_EN,
    output logic                 MEM_W_EN,
    output logic                 WB_EN,
    output logic                 B,
    output logic                 S,
    output logic [3:0]           EXE_CMD,
    output logic [3:0]           SR
);
    localparam int NREG = 2 ** NREG_LOG2;

    typedef struct packed {
        logic                 valid;
        logic [DATA_W-1:0]    pc;
        logic [DATA_W-1:0]    val_rn;
        logic [DATA_W-1:0]    val_rm;
        logic                 imm;
        logic [23:0]          simm24;
        logic [11:0]          shift_op;
        logic [NREG_LOG2-1:0] dest;
        logic [NREG_LOG2-1:0] src1;
        logic [NREG_LOG2-1:0] src2;
        logic                 mem_r_en;
        logic                 mem_w_en;
        logic                 wb_en;
        logic                 b;
        logic                 s;
        logic [3:0]           exe_cmd;
    } idex_t;

    logic [DATA_W-1:0]    rf_q [NREG];
    logic [3:0]           sr_q;
    idex_t                idex_q, idex_d, decoded;

    logic [3:0]           cu_cmd;
    logic                 cu_mem_r, cu_mem_w, cu_wb, cu_b, cu_s;
    logic                 cond_ok, ctrl_ok;
    logic [3:0]           sr_eff;
    logic [NREG_LOG2-1:0] src1, src2;
    logic                 uses_src1, uses_src2;

    ControlUnit u_cu (
        .mode_i     (Instruction_in[27:26]),
        .opcode_i   (Instruction_in[24:21]),
        .s_i        (Instruction_in[20]),
        .exe_cmd_o  (cu_cmd),
        .mem_r_en_o (cu_mem_r),
        .mem_w_en_o (cu_mem_w),
        .wb_en_o    (cu_wb),
        .b_o        (cu_b),
        .s_o        (cu_s)
    );

    assign sr_eff = ((SR_BYPASS != 0) && SR_we) ? SR_in : sr_q;

    Condition_Check u_cc (
        .cond_i    (Instruction_in[31:28]),
        .sr_i      (sr_eff),
        .cond_ok_o (cond_ok)
    );

    // Stores read their data register (Rd) through the second port.
    assign src1 = NREG_LOG2'(Instruction_in[19:16]);
    assign src2 = cu_mem_w ? NREG_LOG2'(Instruction_in[15:12]) : NREG_LOG2'(Instruction_in[3:0]);

    assign uses_src1 = instr_valid && !cu_b;
    assign uses_src2 = instr_valid && (!Instruction_in[25] || cu_mem_w);

    assign hazard = !flush && !rst && (
        (uses_src1 && ((exe_wb_en && exe_dest == src1) || (mem_wb_en && mem_dest == src1))) ||
        (uses_src2 && ((exe_wb_en && exe_dest == src2) || (mem_wb_en && mem_dest == src2))));

    assign ctrl_ok = instr_valid && cond_ok && !hazard;

    always_comb begin
        decoded          = '0;
        decoded.valid    = instr_valid;
        decoded.pc       = PC_in;
        decoded.val_rn   = ((WB_BYPASS != 0) && WB_EN_in && WB_Dest_in == src1) ? WB_Value_in : rf_q[src1];
        decoded.val_rm   = ((WB_BYPASS != 0) && WB_EN_in && WB_Dest_in == src2) ? WB_Value_in : rf_q[src2];
        decoded.imm      = Instruction_in[25];
        decoded.simm24   = Instruction_in[23:0];
        decoded.shift_op = Instruction_in[11:0];
        decoded.dest     = Instruction_in[12 +: NREG_LOG2];
        decoded.src1     = src1;
        decoded.src2     = src2;
        decoded.mem_r_en = ctrl_ok && cu_mem_r;
        decoded.mem_w_en = ctrl_ok && cu_mem_w;
        decoded.wb_en    = ctrl_ok && cu_wb;
        decoded.b        = ctrl_ok && cu_b;
        decoded.s        = ctrl_ok && cu_s;
        decoded.exe_cmd  = ctrl_ok ? cu_cmd : 4'b0000;
    end

    // Flush beats freeze; a hazard only inserts a bubble when the stage is not frozen.
    always_comb begin
        idex_d = idex_q;
        if (flush)        idex_d = '0;
        else if (freeze)  idex_d = idex_q;
        else if (hazard)  idex_d = '0;
        else              idex_d = decoded;
    end

    always_ff @(posedge clk) begin
        if (rst) idex_q <= '0;
        else     idex_q <= idex_d;
    end

    // NOTE: the register file must read as zero after reset, so every entry is cleared here.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (WB_EN_in) begin
            rf_q[WB_Dest_in] <= WB_Value_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)        sr_q <= 4'b0000;
        else if (SR_we) sr_q <= SR_in;
    end

    assign out_valid     = idex_q.valid;
    assign PC            = idex_q.pc;
    assign Val_Rn        = idex_q.val_rn;
    assign Val_Rm        = idex_q.val_rm;
    assign imm           = idex_q.imm;
    assign Signed_imm_24 = idex_q.simm24;
    assign Shift_operand = idex_q.shift_op;
    assign Dest          = idex_q.dest;
    assign src1_out      = idex_q.src1;
    assign src2_out      = idex_q.src2;
    assign MEM_R_EN      = idex_q.mem_r_en;
    assign MEM_W_EN      = idex_q.mem_w_en;
    assign WB_EN         = idex_q.wb_en;
    assign B             = idex_q.b;
    assign S             = idex_q.s;
    assign EXE_CMD       = idex_q.exe_cmd;
    assign SR            = sr_q;
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: a decode/hazard vector table plus
// hand-written sequences for reset, bypass, status, flush and freeze.

module tb_id_stage_pipelined;
    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic        freeze, flush;
    logic        wb_en_in;
    logic [3:0]  wb_dest_in;
    logic [31:0] wb_value_in;
    logic [3:0]  sr_in;
    logic        sr_we;
    logic [3:0]  exe_dest, mem_dest;
    logic        exe_wb_en, mem_wb_en;

    logic        hazard, out_valid, imm_o, mem_r, mem_w, wb_en, b_o, s_o;
    logic [31:0] pc_o, val_rn, val_rm;
    logic [23:0] simm24;
    logic [11:0] shift_op;
    logic [3:0]  dest, src1_o, src2_o, exe_cmd, sr_o;

    logic        b0_hazard, b0_out_valid, b0_imm, b0_mem_r, b0_mem_w, b0_wb_en, b0_b, b0_s;
    logic [31:0] b0_pc, b0_val_rn, b0_val_rm;
    logic [23:0] b0_simm24;
    logic [11:0] b0_shift_op;
    logic [3:0]  b0_dest, b0_src1, b0_src2, b0_exe_cmd, b0_sr;

    int errors = 0;
    int checks = 0;

    id_stage_pipelined dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .Instruction_in(instr), .PC_in(pc_in),
        .freeze(freeze), .flush(flush), .WB_EN_in(wb_en_in), .WB_Dest_in(wb_dest_in),
        .WB_Value_in(wb_value_in), .SR_in(sr_in), .SR_we(sr_we), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .hazard(hazard), .out_valid(out_valid), .PC(pc_o), .Val_Rn(val_rn), .Val_Rm(val_rm),
        .imm(imm_o), .Signed_imm_24(simm24), .Shift_operand(shift_op), .Dest(dest),
        .src1_out(src1_o), .src2_out(src2_o), .MEM_R_EN(mem_r), .MEM_W_EN(mem_w),
        .WB_EN(wb_en), .B(b_o), .S(s_o), .EXE_CMD(exe_cmd), .SR(sr_o)
    );

    id_stage_pipelined #(.WB_BYPASS(0)) dut_nobyp (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .Instruction_in(instr), .PC_in(pc_in),
        .freeze(freeze), .flush(flush), .WB_EN_in(wb_en_in), .WB_Dest_in(wb_dest_in),
        .WB_Value_in(wb_value_in), .SR_in(sr_in), .SR_we(sr_we), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .hazard(b0_hazard), .out_valid(b0_out_valid), .PC(b0_pc), .Val_Rn(b0_val_rn),
        .Val_Rm(b0_val_rm), .imm(b0_imm), .Signed_imm_24(b0_simm24), .Shift_operand(b0_shift_op),
        .Dest(b0_dest), .src1_out(b0_src1), .src2_out(b0_src2), .MEM_R_EN(b0_mem_r),
        .MEM_W_EN(b0_mem_w), .WB_EN(b0_wb_en), .B(b0_b), .S(b0_s), .EXE_CMD(b0_exe_cmd), .SR(b0_sr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic [3:0]  ed;
        logic        ew;
        logic [3:0]  md;
        logic        mw;
        logic        hz;
        logic        ov;
        logic        wb;
        logic [3:0]  cmd;
        logic        mr;
        logic        mwr;
        logic        b;
        logic        s;
        logic [3:0]  dest;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        instr_valid = v.valid; instr = v.instr; pc_in = 32'h1000 + 32'(idx * 4);
        exe_dest = v.ed; exe_wb_en = v.ew; mem_dest = v.md; mem_wb_en = v.mw;
        #1;
        check({tag, ".hazard"}, hazard, v.hz);
        tick();
        check({tag, ".out_valid"}, out_valid, v.ov);
        check({tag, ".WB_EN"}, wb_en, v.wb);
        check({tag, ".EXE_CMD"}, exe_cmd, v.cmd);
        check({tag, ".MEM_R_EN"}, mem_r, v.mr);
        check({tag, ".MEM_W_EN"}, mem_w, v.mwr);
        check({tag, ".B"}, b_o, v.b);
        check({tag, ".S"}, s_o, v.s);
        check({tag, ".Dest"}, dest, v.dest);
    endtask

    initial begin
        // instr valid ed ew md mw | hz ov wb cmd mr mw b s dest
        vecs[0]  = '{32'hE0831003, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[1]  = '{32'hE0831003, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{32'hE0831003, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[3]  = '{32'hE0831003, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[4]  = '{32'hE0831003, 1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[5]  = '{32'hE3A02005, 1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
        vecs[6]  = '{32'hE5814008, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[7]  = '{32'hE5814008, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4};
        vecs[8]  = '{32'hE5925000, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5};
        vecs[9]  = '{32'hEA000010, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[10] = '{32'hE1510002, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[11] = '{32'h03A02005, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
        vecs[12] = '{32'hE0831003, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};

        rst = 1'b1; instr_valid = 1'b0; instr = '0; pc_in = '0; freeze = 1'b0; flush = 1'b0;
        wb_en_in = 1'b0; wb_dest_in = '0; wb_value_in = '0; sr_in = '0; sr_we = 1'b0;
        exe_dest = '0; exe_wb_en = 1'b0; mem_dest = '0; mem_wb_en = 1'b0;

        // Two reset cycles; the write issued during the second must be dropped.
        #1;
        tick();
        wb_en_in = 1'b1; wb_dest_in = 4'd5; wb_value_in = 32'h0000_1234;
        tick();
        rst = 1'b0; wb_en_in = 1'b0;
        #1;
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.PC", pc_o, 32'h0);
        check("rst.Val_Rn", val_rn, 32'h0);
        check("rst.WB_EN", wb_en, 1'b0);
        check("rst.EXE_CMD", exe_cmd, 4'h0);
        check("rst.SR", sr_o, 4'h0);
        check("rst.hazard", hazard, 1'b0);
        tick();
        check("idle.out_valid", out_valid, 1'b0);

        // Every register reads zero after reset (ADD R0,Ri,Ri).
        for (int i = 0; i < 16; i++) begin
            instr_valid = 1'b1;
            instr = 32'hE0800000 | (32'(i) << 16) | 32'(i);
            tick();
            check($sformatf("rf0.Rn%0d", i), val_rn, 32'h0);
            check($sformatf("rf0.Rm%0d", i), val_rm, 32'h0);
        end

        // Same-cycle write-back is forwarded only when the bypass is built in.
        instr = 32'hE0831003; pc_in = 32'h100;
        wb_en_in = 1'b1; wb_dest_in = 4'd3; wb_value_in = 32'hDEADBEEF;
        tick();
        check("byp.Val_Rn", val_rn, 32'hDEADBEEF);
        check("byp.Val_Rm", val_rm, 32'hDEADBEEF);
        check("byp.PC", pc_o, 32'h100);
        check("byp.src1_out", src1_o, 4'd3);
        check("nobyp.Val_Rn", b0_val_rn, 32'h0);
        check("nobyp.Val_Rm", b0_val_rm, 32'h0);
        wb_en_in = 1'b0;
        tick();
        check("rf.Val_Rn", val_rn, 32'hDEADBEEF);
        check("nobyp.rf.Val_Rm", b0_val_rm, 32'hDEADBEEF);

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Branch field capture and immediate flag.
        instr_valid = 1'b1; instr = 32'hEA000010; exe_wb_en = 1'b0; mem_wb_en = 1'b0;
        tick();
        check("b.Signed_imm_24", simm24, 24'h000010);
        check("b.imm", imm_o, 1'b1);

        // Status register: same-cycle SR write lets MOVEQ execute.
        instr = 32'h03A02005; sr_we = 1'b1; sr_in = 4'b0100;
        tick();
        check("sr.byp.out_valid", out_valid, 1'b1);
        check("sr.byp.WB_EN", wb_en, 1'b1);
        check("sr.byp.EXE_CMD", exe_cmd, 4'b0001);
        check("sr.SR", sr_o, 4'b0100);
        sr_we = 1'b0;
        tick();
        check("sr.eq.WB_EN", wb_en, 1'b1);
        instr = 32'h13A02005;
        tick();
        check("sr.ne.WB_EN", wb_en, 1'b0);
        check("sr.ne.out_valid", out_valid, 1'b1);
        instr = 32'h03A02005; sr_we = 1'b1; sr_in = 4'b0000;
        tick();
        check("sr.clr.WB_EN", wb_en, 1'b0);
        sr_we = 1'b0;

        // Flush overrides freeze and masks the hazard.
        instr = 32'hE0831003; pc_in = 32'h200;
        tick();
        check("pre.out_valid", out_valid, 1'b1);
        flush = 1'b1; freeze = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3;
        #1;
        check("flush.hazard", hazard, 1'b0);
        tick();
        check("flush.out_valid", out_valid, 1'b0);
        check("flush.WB_EN", wb_en, 1'b0);
        check("flush.EXE_CMD", exe_cmd, 4'h0);
        check("flush.PC", pc_o, 32'h0);
        flush = 1'b0; freeze = 1'b0; exe_wb_en = 1'b0;
        tick();
        check("load.PC", pc_o, 32'h200);

        // Freeze holds the slot while a different instruction is presented.
        freeze = 1'b1; instr = 32'hE1510002; pc_in = 32'h300;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("frz%0d.PC", i), pc_o, 32'h200);
            check($sformatf("frz%0d.out_valid", i), out_valid, 1'b1);
            check($sformatf("frz%0d.EXE_CMD", i), exe_cmd, 4'b0010);
            check($sformatf("frz%0d.WB_EN", i), wb_en, 1'b1);
        end
        freeze = 1'b0;
        tick();
        check("unfrz.PC", pc_o, 32'h300);
        check("unfrz.EXE_CMD", exe_cmd, 4'b0100);

        // Reset mid-stream empties the slot and the register file.
        instr = 32'hE0831003; rst = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3;
        #1;
        check("mrst.hazard", hazard, 1'b0);
        tick();
        check("mrst.out_valid", out_valid, 1'b0);
        check("mrst.PC", pc_o, 32'h0);
        rst = 1'b0; exe_wb_en = 1'b0;
        tick();
        check("mrst.out_valid2", out_valid, 1'b1);
        check("mrst.Val_Rn", val_rn, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
